// File: rtl/ifetch.sv
// ifetch: in-order instruction fetch with a 2-deep request window, response FIFO and branch redirect
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef INSTR_W
`define INSTR_W 32
`endif

module ifetch #(
  parameter logic [`ADDR_W-1:0] RESET_PC = '0,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                stall,
  input  logic                i_branch_taken,
  input  logic [`ADDR_W-1:0]  i_branch_target,
  output logic                o_imem_req,
  output logic [`ADDR_W-1:0]  o_imem_addr,
  input  logic                i_imem_valid,
  input  logic [`INSTR_W-1:0] i_imem_data,
  output logic [`ADDR_W-1:0]  o_pc,
  output logic [`INSTR_W-1:0] o_instr
);
  localparam int AW = `ADDR_W;
  localparam int IW = `INSTR_W;
  localparam logic [2:0] LIM = 3'(MAX_OUTSTANDING);
  localparam logic [AW-1:0] STEP = AW'(IW / 8);
  localparam logic [AW-1:0] ALIGN = ~AW'(3);
  logic [1:0] o_q, o_d, f_q, f_d, d_q, d_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] p_q [2];
  logic [AW-1:0] p_d [2];
  logic [AW-1:0] fp_q [2];
  logic [AW-1:0] fp_d [2];
  logic [IW-1:0] fi_q [2];
  logic [IW-1:0] fi_d [2];
  logic pop, req, rsp, keep, show, pw, fw;
  assign pop = ~clr & ~i_branch_taken & ~stall & (f_q != 2'd0);
  assign req = ~clr & ~i_branch_taken & ((3'(o_q) + 3'(f_q) - 3'(pop)) < LIM);
  // a strobe with nothing outstanding is illegal and simply ignored
  assign rsp = i_imem_valid & (o_q != 2'd0);
  assign keep = rsp & (d_q == 2'd0);
  // slots are shift-style, so the write slot is occupancy after this cycle's pop
  assign pw = o_q[0] ^ rsp;
  assign fw = f_q[0] ^ pop;
  assign show = ~clr & ~i_branch_taken & (f_q != 2'd0);
  assign o_imem_req = req;
  assign o_imem_addr = pc_q;
  assign o_pc = show ? fp_q[0] : '0;
  assign o_instr = show ? fi_q[0] : '0;
  always_comb begin
    pc_d = i_branch_taken ? (i_branch_target & ALIGN) : req ? pc_q + STEP : pc_q;
    o_d = o_q + 2'(req) - 2'(rsp);
    f_d = i_branch_taken ? 2'd0 : f_q + 2'(keep) - 2'(pop);
    // a redirect drops everything still in flight after this cycle's response
    d_d = i_branch_taken ? o_q - 2'(rsp) : d_q - 2'(rsp & ~keep);
    p_d[0] = rsp ? p_q[1] : p_q[0];
    p_d[1] = p_q[1];
    if (req) p_d[pw] = pc_q;
    fp_d[0] = pop ? fp_q[1] : fp_q[0];
    fp_d[1] = fp_q[1];
    fi_d[0] = pop ? fi_q[1] : fi_q[0];
    fi_d[1] = fi_q[1];
    if (keep) begin
      fp_d[fw] = p_q[0];
      fi_d[fw] = i_imem_data;
    end
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q <= RESET_PC;
      o_q <= '0;
      f_q <= '0;
      d_q <= '0;
    end else begin
      pc_q <= pc_d;
      o_q <= o_d;
      f_q <= f_d;
      d_q <= d_d;
    end
  end
  always_ff @(posedge clk) begin
    p_q <= p_d;
    fp_q <= fp_d;
    fi_q <= fi_d;
  end
endmodule
